// File: rtl/hs_cdc_pulse_tx_pacer.sv
// hs_cdc_pulse_tx_pacer: queues source pulses and sends them as req toggles.
// Define HS_PULSE_TX_TIMEOUT_EN to add the sticky ack timeout flag.
package hs_cdc_pulse_pkg;
    typedef enum logic {
        LEVEL_LOW  = 1'b0,
        LEVEL_HIGH = 1'b1
    } level_e;
endpackage

module hs_cdc_syncer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic aresetn,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync;

    // shift the asynchronous level through the flop chain
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];
endmodule

module hs_cdc_pulse_tx_pacer
    import hs_cdc_pulse_pkg::*;
#(
    parameter level_e ACTIVE_LEVEL   = LEVEL_HIGH,
    parameter int     MAX_PENDING    = 15,
    parameter int     SYNC_STAGE     = 2,
    parameter int     TIMEOUT_CYCLES = 1024,
    localparam int    PW = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          pulse_in,
    output logic          req_lvl,
    input  logic          ack_lvl,
    output logic [PW-1:0] pending,
    output logic          busy,
    output logic          overflow,
    input  logic          overflow_sclr,
    output logic          timeout_err
);
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          ack_s;
    logic          pv;
    logic          launch;
    logic          has_q;
    logic          consume;
    logic          enq;
    logic          full;
    logic          drop;
    logic [PW-1:0] pending_nxt;

    hs_cdc_syncer #(
        .STAGES (SYNC_STAGE)
    ) u_ack_sync (
        .clk     (clk),
        .aresetn (aresetn),
        .d       (ack_lvl),
        .q       (ack_s)
    );

    assign pv      = (pulse_in == logic'(ACTIVE_LEVEL));
    assign has_q   = (pending != '0);
    assign full    = (pending == PW'(MAX_PENDING));
    assign busy    = (state == WAIT_ACK);

    // launch from IDLE, wait for the synchronized echo before the next one
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        unique case (state)
            IDLE: begin
                if (pv || has_q) begin
                    launch    = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_s == req_lvl) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // queue accounting: a launch with an empty queue bypasses it
    always_comb begin
        consume     = launch & has_q;
        enq         = pv & ~(launch & ~has_q);
        drop        = enq & ~consume & full;
        pending_nxt = pending;
        if (consume && !enq) begin
            pending_nxt = pending - PW'(1);
        end else if (enq && !consume && !full) begin
            pending_nxt = pending + PW'(1);
        end
    end

    // state, toggle level, queue count and sticky overflow
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            req_lvl  <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (launch) begin
                req_lvl <= ~req_lvl;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_sclr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef HS_PULSE_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmr;

    // count unacknowledged WAIT_ACK cycles; the flag holds until reset
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tmr         <= '0;
            timeout_err <= 1'b0;
        end else if (launch) begin
            tmr <= '0;
        end else if (busy && (ack_s != req_lvl)) begin
            if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout_err <= 1'b1;
            end else begin
                tmr <= tmr + TW'(1);
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_hs_cdc_pulse_tx_pacer.sv
// tb_hs_cdc_pulse_tx_pacer: directed and random checks of the pulse pacer.
// Reference model tracks queue count, toggle level and ack delay abstractly.
`timescale 1ns/1ps
module tb_hs_cdc_pulse_tx_pacer;
    import hs_cdc_pulse_pkg::*;

    localparam int MAXP = 4;
    localparam int SYNC = 2;
    localparam int TMO  = 8;
    localparam int PW   = $clog2(MAXP + 1);
`ifdef HS_PULSE_TX_TIMEOUT_EN
    localparam int TMO_EN = 1;
`else
    localparam int TMO_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          pulse_in = 1'b0;
    logic          ack_man = 1'b0;
    logic          loopb = 1'b0;
    logic          overflow_sclr = 1'b0;
    logic          req_lvl;
    logic          ack_lvl;
    logic          busy;
    logic          overflow;
    logic          timeout_err;
    logic [PW-1:0] pending;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    assign ack_lvl = loopb ? req_lvl : ack_man;

    always #5 clk = ~clk;

    hs_cdc_pulse_tx_pacer #(
        .ACTIVE_LEVEL   (LEVEL_HIGH),
        .MAX_PENDING    (MAXP),
        .SYNC_STAGE     (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .pulse_in      (pulse_in),
        .req_lvl       (req_lvl),
        .ack_lvl       (ack_lvl),
        .pending       (pending),
        .busy          (busy),
        .overflow      (overflow),
        .overflow_sclr (overflow_sclr),
        .timeout_err   (timeout_err)
    );

    // reference model state
    int m_pend;
    bit m_req;
    bit m_busy;
    bit m_ovf;
    bit m_terr;
    int m_wait;
    bit m_hist[$];

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pend = 0;
        m_req  = 0;
        m_busy = 0;
        m_ovf  = 0;
        m_terr = 0;
        m_wait = 0;
        m_hist = {};
        for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    endtask

    // model: one step per rising edge from the inputs held before it
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_reset();
        end else begin
            bit pv;
            bit ackin;
            bit acks;
            bit launch;
            bit drop;
            pv     = pulse_in;
            ackin  = loopb ? m_req : ack_man;
            acks   = m_hist[0];
            launch = !m_busy && (pv || m_pend > 0);
            drop   = 0;
            if (launch) begin
                if (m_pend > 0) m_pend = m_pend - 1 + int'(pv);
            end else if (pv) begin
                if (m_pend == MAXP) drop = 1;
                else m_pend++;
            end
            if (drop) m_ovf = 1;
            else if (overflow_sclr) m_ovf = 0;
            if (launch) begin
                m_req  = !m_req;
                m_busy = 1;
                m_wait = 0;
            end else if (m_busy) begin
                if (acks == m_req) begin
                    m_busy = 0;
                end else begin
                    m_wait++;
                    if (m_wait >= TMO) m_terr = 1;
                end
            end
            void'(m_hist.pop_front());
            m_hist.push_back(ackin);
        end
    end

    // compare DUT against model every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_req", int'(req_lvl), int'(m_req));
            check("cyc_pending", int'(pending), m_pend);
            check("cyc_busy", int'(busy), int'(m_busy));
            check("cyc_overflow", int'(overflow), int'(m_ovf));
            check("cyc_timeout", int'(timeout_err), TMO_EN != 0 ? int'(m_terr) : 0);
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 aresetn = 1'b0;
        @(negedge clk);
        #1 aresetn = 1'b1;
    endtask

    initial begin
        int nb;
        int tog;
        bit prev;
        m_reset();
        chk_en = 1;
        repeat (2) @(negedge clk);
        check("rst_req", int'(req_lvl), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_timeout", int'(timeout_err), 0);
        #1 aresetn = 1'b1;

        // single pulse with ack looped back
        pulse_in = 1'b1;
        loopb = 1'b1;
        @(negedge clk);
        pulse_in = 1'b0;
        check("t1_req", int'(req_lvl), 1);
        check("t1_pending", int'(pending), 0);
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) nb++;
            @(negedge clk);
        end
        check("t1_busy_cycles", nb, SYNC + 1);

        // six back-to-back pulses with ack held low
        loopb = 1'b0;
        ack_man = 1'b0;
        do_reset();
        pulse_in = 1'b1;
        repeat (6) @(negedge clk);
        pulse_in = 1'b0;
        check("t2_req", int'(req_lvl), 1);
        check("t2_pending", int'(pending), 4);
        check("t2_overflow", int'(overflow), 1);

        // release ack and drain the queue
        loopb = 1'b1;
        prev = req_lvl;
        tog = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_lvl != prev) tog++;
            prev = req_lvl;
        end
        check("t3_toggles", tog, 4);
        check("t3_pending", int'(pending), 0);
        check("t3_busy", int'(busy), 0);

        // new pulse on the same cycle as a queued launch
        loopb = 1'b0;
        ack_man = 1'b0;
        do_reset();
        pulse_in = 1'b1;
        repeat (3) @(negedge clk);
        pulse_in = 1'b0;
        check("t4_pending_pre", int'(pending), 2);
        ack_man = 1'b1;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check("t4_idle_reached", int'(busy), 0);
        pulse_in = 1'b1;
        @(negedge clk);
        pulse_in = 1'b0;
        check("t4_pending", int'(pending), 2);
        check("t4_req", int'(req_lvl), 0);
        check("t4_overflow", int'(overflow), 0);

        // reset in the middle of WAIT_ACK with three queued
        pulse_in = 1'b1;
        @(negedge clk);
        pulse_in = 1'b0;
        check("t5_pending_pre", int'(pending), 3);
        check("t5_busy_pre", int'(busy), 1);
        @(posedge clk);
        #2 aresetn = 1'b0;
        #1;
        check("t5_req_rst", int'(req_lvl), 0);
        check("t5_pending_rst", int'(pending), 0);
        check("t5_busy_rst", int'(busy), 0);
        check("t5_overflow_rst", int'(overflow), 0);
        @(negedge clk);
        #1 aresetn = 1'b1;
        loopb = 1'b1;
        pulse_in = 1'b1;
        @(negedge clk);
        pulse_in = 1'b0;
        check("t5_req_after", int'(req_lvl), 1);
        check("t5_pending_after", int'(pending), 0);

        // overflow clear racing a drop, then a plain clear
        loopb = 1'b0;
        ack_man = 1'b0;
        do_reset();
        pulse_in = 1'b1;
        repeat (6) @(negedge clk);
        overflow_sclr = 1'b1;
        @(negedge clk);
        overflow_sclr = 1'b0;
        pulse_in = 1'b0;
        check("t6_ovf_drop_wins", int'(overflow), 1);
        check("t6_pending", int'(pending), 4);
        overflow_sclr = 1'b1;
        @(negedge clk);
        overflow_sclr = 1'b0;
        check("t6_ovf_cleared", int'(overflow), 0);
        repeat (TMO) @(negedge clk);
        check("t6_timeout", int'(timeout_err), TMO_EN);

        // randomized traffic against the model
        begin
            int dens;
            dens = 30;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                if (i % 256 == 0) dens = $urandom_range(5, 95);
                if (i % 200 == 0) loopb = $urandom_range(0, 1) != 0;
                pulse_in = $urandom_range(0, 99) < dens;
                overflow_sclr = $urandom_range(0, 31) == 0;
                if ($urandom_range(0, 7) == 0) ack_man = ~ack_man;
                if ($urandom_range(0, 499) == 0) do_reset();
            end
        end
        pulse_in = 1'b0;
        overflow_sclr = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
